// File: rtl/packet_splitter_if.sv
// FIFO-side bundle of the packet splitter: one FWFT input FIFO, two output FIFOs,
// plus the debug counters and the sticky length error.
interface packet_splitter_if #(
    parameter int W     = 11,
    parameter int CNT_W = 16
);
    // Handshake: a flit moves when the input is non-empty (valid) and the selected
    // output is not full (ready); rd and the selected wr pulse in that same cycle.
    logic             in_FIFO_empty;
    logic [W-1:0]     data_in;
    logic             in_FIFO_rd;
    logic             out_FIFO_full_0;
    logic             out_FIFO_full_1;
    logic             out_FIFO_wr_0;
    logic             out_FIFO_wr_1;
    logic [W-1:0]     data_out_0;
    logic [W-1:0]     data_out_1;
    logic [CNT_W-1:0] pkt_cnt_0;
    logic [CNT_W-1:0] pkt_cnt_1;
    logic             err_len;
    logic             err_clr;

    modport slave (
        input  in_FIFO_empty, data_in, out_FIFO_full_0, out_FIFO_full_1, err_clr,
        output in_FIFO_rd, out_FIFO_wr_0, out_FIFO_wr_1, data_out_0, data_out_1,
        output pkt_cnt_0, pkt_cnt_1, err_len
    );

    modport master (
        output in_FIFO_empty, data_in, out_FIFO_full_0, out_FIFO_full_1, err_clr,
        input  in_FIFO_rd, out_FIFO_wr_0, out_FIFO_wr_1, data_out_0, data_out_1,
        input  pkt_cnt_0, pkt_cnt_1, err_len
    );
endinterface

// File: rtl/packet_splitter.sv
// Steers whole wormhole packets from one input FIFO to one of two output FIFOs,
// chosen by the route bit of the head flit; counts packets and flags over-length ones.
module packet_splitter #(
    parameter int W         = 11,
    parameter int ROUTE_BIT = 9,
    parameter int MAX_LEN   = 64,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    packet_splitter_if.slave     bus,
    output logic [1:0]           state_o
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROUTE_0 = 2'd1,
        ROUTE_1 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d, len_inc;
    logic [CNT_W-1:0] pkt_cnt_0_q, pkt_cnt_1_q;
    logic             err_q, err_d;
    logic             sel, tail, xfer;
    logic             done_0, done_1, set_err;

    always_comb begin
        sel     = (state_q == IDLE) ? bus.data_in[ROUTE_BIT] : (state_q == ROUTE_1);
        tail    = bus.data_in[W-1];
        // Gating with reset_n keeps all strobes low for the whole reset window.
        xfer    = reset_n && !bus.in_FIFO_empty &&
                  !(sel ? bus.out_FIFO_full_1 : bus.out_FIFO_full_0);
        len_inc = len_q + LEN_W'(1);

        state_d = state_q;
        len_d   = len_q;
        done_0  = 1'b0;
        done_1  = 1'b0;
        set_err = 1'b0;

        if (xfer) begin
            if (state_q == IDLE) begin
                if (tail) begin
                    done_0 = !sel;
                    done_1 = sel;
                end else begin
                    state_d = sel ? ROUTE_1 : ROUTE_0;
                    len_d   = LEN_W'(1);
                end
            end else if (tail || len_inc == LEN_W'(MAX_LEN)) begin
                // Reaching MAX_LEN without a tail truncates the packet; the next flit is a head.
                state_d = IDLE;
                len_d   = '0;
                done_0  = !sel;
                done_1  = sel;
                set_err = !tail;
            end else begin
                len_d = len_inc;
            end
        end

        err_d = set_err ? 1'b1 : (bus.err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            pkt_cnt_0_q <= '0;
            pkt_cnt_1_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            pkt_cnt_0_q <= pkt_cnt_0_q + CNT_W'(done_0);
            pkt_cnt_1_q <= pkt_cnt_1_q + CNT_W'(done_1);
            err_q       <= err_d;
        end
    end

    assign bus.in_FIFO_rd    = xfer;
    assign bus.out_FIFO_wr_0 = xfer && !sel;
    assign bus.out_FIFO_wr_1 = xfer && sel;
    assign bus.data_out_0    = bus.data_in;
    assign bus.data_out_1    = bus.data_in;
    assign bus.pkt_cnt_0     = pkt_cnt_0_q;
    assign bus.pkt_cnt_1     = pkt_cnt_1_q;
    assign bus.err_len       = err_q;
    assign state_o           = state_q;
endmodule

// File: tb/tb_packet_splitter.sv
// Bench for packet_splitter: flit-stream reference model, per-cycle compare on the
// falling edge, directed scenarios with literal expectations, then random traffic.
module tb_packet_splitter;
    localparam int W  = 11;
    localparam int RB = 9;
    localparam int ML = 4;
    localparam int CW = 2;

    typedef struct packed {
        logic [W-1:0] f;
        bit           port;
        bit           done;
        bit           err;
    } ent_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] state_o;

    packet_splitter_if #(.W(W), .CNT_W(CW)) bus ();

    packet_splitter #(.W(W), .ROUTE_BIT(RB), .MAX_LEN(ML), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .state_o (state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus state and reference model ----------------
    ent_t         src_q[$];
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    bit           p_in;
    bit           p_port;
    int           p_len;
    int           m_cnt0, m_cnt1;
    bit           m_err;
    bit           pop_pending;
    bit           rand_mode;
    bit           force_full0, force_full1, clr_req;
    int           n_pass, n_total;
    ent_t         c_e;
    bit           c_acc, c_port;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Routing of a flit stream does not depend on timing, so each flit's port and
    // packet-completion effects are decided when it is queued.
    function automatic void push_flit(input logic [W-1:0] f);
        ent_t e;
        e.f = f; e.done = 1'b0; e.err = 1'b0; e.port = 1'b0;
        if (!p_in) begin
            e.port = f[RB];
            if (f[W-1]) e.done = 1'b1;
            else begin p_in = 1'b1; p_port = e.port; p_len = 1; end
        end else begin
            e.port = p_port;
            p_len++;
            if (f[W-1]) begin e.done = 1'b1; p_in = 1'b0; end
            else if (p_len == ML) begin e.done = 1'b1; e.err = 1'b1; p_in = 1'b0; end
        end
        src_q.push_back(e);
        if (e.port) exp_q1.push_back(f);
        else exp_q0.push_back(f);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_inputs();
        bus.in_FIFO_empty   = (src_q.size() == 0) || (rand_mode && $urandom_range(0, 3) == 0);
        bus.data_in         = (src_q.size() > 0) ? src_q[0].f : W'($urandom);
        bus.out_FIFO_full_0 = rand_mode ? ($urandom_range(0, 3) == 0) : force_full0;
        bus.out_FIFO_full_1 = rand_mode ? ($urandom_range(0, 3) == 0) : force_full1;
        bus.err_clr         = rand_mode ? ($urandom_range(0, 7) == 0) : clr_req;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (pop_pending && src_q.size() > 0) void'(src_q.pop_front());
        pop_pending = 1'b0;
        set_inputs();
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (src_q.size() > 0 && n < limit) begin cycle(); n++; end
        check("drain_in_time", n < limit, 1);
    endtask

    task automatic run_until(input int left);
        int n = 0;
        while (src_q.size() > left && n < 200) begin cycle(); n++; end
        check("reach_point", n < 200, 1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        src_q.delete(); exp_q0.delete(); exp_q1.delete();
        p_in = 1'b0; p_port = 1'b0; p_len = 0;
        pop_pending = 1'b0;
        set_inputs();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // ---------------- compare process / scoreboard ----------------
    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_rd", bus.in_FIFO_rd, 0);
            check("rst_wr_0", bus.out_FIFO_wr_0, 0);
            check("rst_wr_1", bus.out_FIFO_wr_1, 0);
            check("rst_cnt_0", bus.pkt_cnt_0, 0);
            check("rst_cnt_1", bus.pkt_cnt_1, 0);
            check("rst_err", bus.err_len, 0);
            m_cnt0 = 0; m_cnt1 = 0; m_err = 1'b0;
            pop_pending = 1'b0;
        end else begin
            c_acc = 1'b0; c_port = 1'b0; c_e = '0;
            if (src_q.size() > 0) begin
                c_e    = src_q[0];
                c_port = c_e.port;
                c_acc  = !bus.in_FIFO_empty &&
                         !(c_port ? bus.out_FIFO_full_1 : bus.out_FIFO_full_0);
            end
            check("rd", bus.in_FIFO_rd, c_acc);
            check("wr_0", bus.out_FIFO_wr_0, c_acc && !c_port);
            check("wr_1", bus.out_FIFO_wr_1, c_acc && c_port);
            check("data_out_0", bus.data_out_0, bus.data_in);
            check("data_out_1", bus.data_out_1, bus.data_in);
            check("pkt_cnt_0", bus.pkt_cnt_0, m_cnt0);
            check("pkt_cnt_1", bus.pkt_cnt_1, m_cnt1);
            check("err_len", bus.err_len, m_err);
            if (bus.out_FIFO_wr_0) begin
                if (exp_q0.size() == 0) check("sb_0_extra", 1, 0);
                else check("sb_0", bus.data_out_0, exp_q0.pop_front());
            end
            if (bus.out_FIFO_wr_1) begin
                if (exp_q1.size() == 0) check("sb_1_extra", 1, 0);
                else check("sb_1", bus.data_out_1, exp_q1.pop_front());
            end
            if (c_acc && c_e.done) begin
                if (c_port) m_cnt1 = (m_cnt1 + 1) % (1 << CW);
                else m_cnt0 = (m_cnt0 + 1) % (1 << CW);
            end
            m_err = (c_acc && c_e.err) ? 1'b1 : (bus.err_clr ? 1'b0 : m_err);
            pop_pending = bus.in_FIFO_rd;
        end
    end

    // ---------------- main sequence ----------------
    int           wrap_seq[5] = '{1, 2, 3, 0, 1};
    logic [W-1:0] f;
    int           len;

    initial begin
        n_pass = 0; n_total = 0;
        rand_mode = 1'b0; force_full0 = 1'b0; force_full1 = 1'b0; clr_req = 1'b0;
        do_reset();

        // single-flit packets to port 1 then port 0
        push_flit(11'h600);
        push_flit(11'h400);
        drain(50);
        check("t1_cnt_0", bus.pkt_cnt_0, 1);
        check("t1_cnt_1", bus.pkt_cnt_1, 1);
        check("t1_idle", state_o, 0);

        // 3-flit packet to port 0, body route bit ignored
        push_flit(11'h0AB);
        push_flit(11'h2CD);
        push_flit(11'h4EF);
        drain(50);
        check("t2_cnt_0", bus.pkt_cnt_0, 2);
        check("t2_cnt_1", bus.pkt_cnt_1, 1);

        // port 1 full for 4 cycles mid-packet
        push_flit(11'h201);
        push_flit(11'h002);
        push_flit(11'h003);
        push_flit(11'h404);
        run_until(2);
        force_full1 = 1'b1;
        set_inputs();
        repeat (4) cycle();
        check("t3_stalled", src_q.size(), 2);
        force_full1 = 1'b0;
        set_inputs();
        drain(50);
        check("t3_cnt_1", bus.pkt_cnt_1, 2);
        check("t3_err", bus.err_len, 0);

        // over-length: 4 flits truncate, the 5th is a fresh head routed to port 1
        push_flit(11'h001);
        push_flit(11'h002);
        push_flit(11'h003);
        push_flit(11'h004);
        push_flit(11'h205);
        push_flit(11'h006);
        push_flit(11'h407);
        drain(50);
        check("t4_err", bus.err_len, 1);
        check("t4_cnt_0", bus.pkt_cnt_0, 3);
        check("t4_cnt_1", bus.pkt_cnt_1, 3);
        clr_req = 1'b1;
        set_inputs();
        cycle();
        clr_req = 1'b0;
        set_inputs();
        check("t4_err_clr", bus.err_len, 0);

        // reset in the middle of a 5-flit packet to port 1
        push_flit(11'h211);
        push_flit(11'h012);
        push_flit(11'h013);
        push_flit(11'h014);
        push_flit(11'h415);
        run_until(3);
        reset_n = 1'b0;
        #2;
        check("t5_rd_low", bus.in_FIFO_rd, 0);
        check("t5_wr_1_low", bus.out_FIFO_wr_1, 0);
        check("t5_cnt_1", bus.pkt_cnt_1, 0);
        do_reset();
        push_flit(11'h421);
        drain(50);
        check("t5_cnt_0", bus.pkt_cnt_0, 1);
        check("t5_cnt_1_after", bus.pkt_cnt_1, 0);

        // counter wrap with 2-bit counters
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push_flit(W'(11'h400 + i));
            drain(50);
            check("t6_wrap", bus.pkt_cnt_0, wrap_seq[i]);
        end

        // random traffic with gaps, backpressure and err_clr pulses
        rand_mode = 1'b1;
        for (int p = 0; p < 200; p++) begin
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) begin
                f = W'($urandom);
                f[W-1] = (j == len - 1);
                push_flit(f);
            end
        end
        set_inputs();
        drain(20000);
        rand_mode = 1'b0;
        set_inputs();
        repeat (2) cycle();
        check("t7_q0_empty", exp_q0.size(), 0);
        check("t7_q1_empty", exp_q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
